// File: rtl/branch_target_if.sv
// Branch-target handshake: request/operands from the sequencer,
// PC-load strobes and busy/done status back to it.
interface branch_target_if #(
  parameter int PC_WIDTH = 16
);
  logic                branch;
  logic [7:0]          offset;
  logic [PC_WIDTH-1:0] pc_in;
  logic [PC_WIDTH-1:0] target_pc;
  logic                pc_load;
  logic                busy;
  logic                page_cross;
  logic                done;

  modport master (
    output branch, offset, pc_in,
    input  target_pc, pc_load, busy,
    input  page_cross, done
  );

  modport slave (
    input  branch, offset, pc_in,
    output target_pc, pc_load, busy,
    output page_cross, done
  );
endinterface

// File: rtl/branch_target.sv
// Taken-branch target: low-byte add, then an optional PCH
// fix-up cycle on page cross (6502 timing).
module branch_target #(
  parameter bit PAGE_FIX_CYCLE = 1'b1,
  parameter int PC_WIDTH       = 16
) (
  input logic            clk_2,
  input logic            rst,
  branch_target_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADD_LOW,
    S_FIX_HIGH
  } state_t;

  state_t r_state;
  state_t w_state_nx;

  logic [7:0] r_pch;
  logic [7:0] r_pcl;
  logic [7:0] r_off;

  logic [PC_WIDTH-1:0] r_target;
  logic                r_pc_load;
  logic                r_busy;
  logic                r_page_cross;
  logic                r_done;

  logic [PC_WIDTH-1:0] w_target_nx;
  logic                w_load_nx;
  logic                w_busy_nx;
  logic                w_pcx_nx;
  logic                w_done_nx;

  logic       w_take;
  logic [8:0] w_sum_in;
  logic       w_fix_in;
  logic [7:0] w_adj_in;
  logic [8:0] w_sum_r;
  logic       w_fix_r;
  logic [7:0] w_adj_r;

  assign w_take = (r_state == S_IDLE) && bus.branch;

  // Operands straight from the bus feed the ADD_LOW outputs
  assign w_sum_in = {1'b0, bus.pc_in[7:0]}
                  + {1'b0, bus.offset};
  assign w_fix_in = w_sum_in[8] ^ bus.offset[7];
  assign w_adj_in = bus.offset[7]
                  ? bus.pc_in[15:8] - 8'd1
                  : bus.pc_in[15:8] + 8'd1;

  // Latched operands feed the FIX_HIGH outputs
  assign w_sum_r = {1'b0, r_pcl} + {1'b0, r_off};
  assign w_fix_r = w_sum_r[8] ^ r_off[7];
  assign w_adj_r = r_off[7] ? r_pch - 8'd1
                            : r_pch + 8'd1;

  always_ff @(posedge clk_2 or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (bus.branch) w_state_nx = S_ADD_LOW;
      end
      S_ADD_LOW: begin
        if (w_fix_r && PAGE_FIX_CYCLE)
          w_state_nx = S_FIX_HIGH;
        else
          w_state_nx = S_IDLE;
      end
      S_FIX_HIGH: w_state_nx = S_IDLE;
      default:    w_state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    w_target_nx = r_target;
    w_load_nx   = 1'b0;
    w_busy_nx   = 1'b0;
    w_pcx_nx    = 1'b0;
    w_done_nx   = 1'b0;
    unique case (1'b1)
      w_take: begin
        w_load_nx = 1'b1;
        w_busy_nx = 1'b1;
        if (w_fix_in && !PAGE_FIX_CYCLE) begin
          w_target_nx = {w_adj_in, w_sum_in[7:0]};
          w_pcx_nx    = 1'b1;
          w_done_nx   = 1'b1;
        end else begin
          w_target_nx = {bus.pc_in[15:8],
                         w_sum_in[7:0]};
          w_done_nx   = !w_fix_in;
        end
      end
      (w_state_nx == S_FIX_HIGH): begin
        w_target_nx = {w_adj_r, w_sum_r[7:0]};
        w_load_nx   = 1'b1;
        w_busy_nx   = 1'b1;
        w_pcx_nx    = 1'b1;
        w_done_nx   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_2 or posedge rst) begin
    if (rst) begin
      r_pch        <= 8'h00;
      r_pcl        <= 8'h00;
      r_off        <= 8'h00;
      r_target     <= '0;
      r_pc_load    <= 1'b0;
      r_busy       <= 1'b0;
      r_page_cross <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      if (w_take) begin
        r_pch <= bus.pc_in[15:8];
        r_pcl <= bus.pc_in[7:0];
        r_off <= bus.offset;
      end
      r_target     <= w_target_nx;
      r_pc_load    <= w_load_nx;
      r_busy       <= w_busy_nx;
      r_page_cross <= w_pcx_nx;
      r_done       <= w_done_nx;
    end
  end

  assign bus.target_pc  = r_target;
  assign bus.pc_load    = r_pc_load;
  assign bus.busy       = r_busy;
  assign bus.page_cross = r_page_cross;
  assign bus.done       = r_done;

endmodule

// File: doc/branch_target.md
Name: branch_target

Overview:
- PC-side consumer of the branch decision. When the branch unit asserts branch, this block computes the taken-branch target PC + signed 8-bit offset with 6502 cycle timing.
- The low byte is added first. The page (PCH) is corrected in an extra cycle only when the add crosses a page.
- Drives PC-load strobes into the program-counter register and a busy/done handshake toward the sequencer.

Parameters:
PAGE_FIX_CYCLE, 1, 1 = 6502 timing (separate PCH fix-up cycle on page cross); 0 = full 16-bit add in ADD_LOW, no FIX_HIGH state
PC_WIDTH, 16, program counter width; fixed at 16, present for port sizing only

Ports:
clk_2  input  1  system clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
branch  input  1  taken-branch request (branch_uncon | branch_con&test | internal); sampled only in IDLE
offset  input  8  signed two's-complement branch displacement (operand byte from data_bus); sampled with branch
pc_in  input  16  PC already pointing past the operand byte; sampled with branch
target_pc  output  16  PC value to load; valid when pc_load=1
pc_load  output  1  one-cycle strobe: PC register loads target_pc
busy  output  1  1 while in ADD_LOW or FIX_HIGH
page_cross  output  1  1 during the cycle that completes a page-crossing branch
done  output  1  one-cycle pulse in the final cycle of a branch

Behaviour:
- Reset (async, rst=1): state=IDLE. target_pc=0x0000; pc_load, busy, page_cross and done all 0. Latched pch/pcl/offset are cleared to 0. Reset takes effect mid-operation immediately, with no pending load.
- States: IDLE, ADD_LOW, FIX_HIGH.
- IDLE:
  - On branch=1 at clk_2 rising edge: latch pch=pc_in[15:8], pcl=pc_in[7:0], off=offset; go to ADD_LOW.
  - Otherwise stay.
  - Outputs: pc_load=0, busy=0, done=0.
- ADD_LOW (one cycle, registered outputs asserted during this state):
  - sum9 = {1'b0,pcl} + {1'b0,off}; lo = sum9[7:0]; c = sum9[8]; s = off[7].
  - fix = c XOR s. c=1, s=0 means PCH+1; c=0, s=1 means PCH-1; otherwise no fix.
  - target_pc={pch,lo}, pc_load=1, busy=1.
  - If fix=0: done=1, page_cross=0, next state IDLE.
  - If fix=1 and PAGE_FIX_CYCLE=1: done=0, next state FIX_HIGH. The intermediate wrong-page PC is loaded deliberately, matching the 6502 dummy fetch.
  - If fix=1 and PAGE_FIX_CYCLE=0: target_pc={pch±1,lo}, done=1, page_cross=1, next state IDLE.
- FIX_HIGH (one cycle):
  - pch' = pch+1 when s=0, pch-1 when s=1, modulo 256.
  - target_pc={pch',lo}, pc_load=1, busy=1, done=1, page_cross=1; next state IDLE.
- Latency from branch sample: no cross = 1 cycle to done; cross = 2 cycles (PAGE_FIX_CYCLE=1) or 1 cycle (PAGE_FIX_CYCLE=0).
- Wrap-around: PCH 0xFF+1 becomes 0x00; PCH 0x00-1 becomes 0xFF. The 16-bit address space wraps with no flag.
- branch asserted while busy=1 is ignored and not queued; offset and pc_in are don't-care outside the IDLE sample.
- branch on the same edge that returns to IDLE (done=1) is not sampled. The next request is accepted one cycle after done.
- Offset 0x00: target = pc_in, no cross, 1 cycle. Offset 0x80 (-128) is handled per the same arithmetic.
- Outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- pc_in=0x1234, offset=0x10, branch pulse -> next cycle target_pc=0x1244, pc_load=1, done=1, page_cross=0; then IDLE with busy=0.
- pc_in=0x12F0, offset=0x20 -> cycle1: target_pc=0x1210, pc_load=1, done=0; cycle2: target_pc=0x1310, pc_load=1, done=1, page_cross=1.
- pc_in=0x1205, offset=0xF0 (-16) -> cycle1 target_pc=0x12F5; cycle2 target_pc=0x11F5, page_cross=1. Also pc_in=0x1280, offset=0x80 -> 0x1200, no cross, 1 cycle.
- Wrap: pc_in=0xFFF0, offset=0x20 -> 0xFF10 then 0x0010. pc_in=0x0005, offset=0xF0 -> 0x00F5 then 0xFFF5.
- branch held high through a crossing branch -> exactly one branch executes; second request accepted only after done. rst pulsed during FIX_HIGH -> outputs 0 immediately, no pc_load on the following edge.
- PAGE_FIX_CYCLE=0 build: pc_in=0x12F0, offset=0x20 -> single cycle target_pc=0x1310, pc_load=1, done=1, page_cross=1.
